// File: rtl/ship_sprite_renderer.sv
// ship_sprite_renderer: erases the previously drawn 8x4 ship sprite and redraws it at a new x,
// streaming one pixel per cycle to the VGA adapter plot interface.
module ship_sprite_renderer #(
  parameter int          SCREEN_W  = 160,
  parameter int          SHIP_Y    = 112,
  parameter int          SHIP_W    = 8,
  parameter int          SHIP_H    = 4,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       update,
  input  logic [7:0] x_in,
  input  logic [2:0] colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, CHECK, ERASE, DRAW, DONE} state_t;
  localparam logic [7:0] XMAX = 8'(SCREEN_W - SHIP_W);
  localparam logic [4:0] LAST = 5'(SHIP_W * SHIP_H - 1);
  state_t     r_state, w_next;
  logic [4:0] r_cnt;
  logic [7:0] r_pos, r_xr;
  logic       r_drawn;
  logic [2:0] r_col, r_dcol;
  logic [1:0] w_row;
  logic [2:0] w_cidx;
  logic [7:0] w_line;
  logic       w_act, w_last;
  assign w_row  = r_cnt[4:3];
  assign w_cidx = r_cnt[2:0];
  assign w_act  = (r_state == ERASE) || (r_state == DRAW);
  assign w_last = w_act && (r_cnt == LAST);
  // ship silhouette: a 2-4-6-8 pixel pyramid centred in the 8-wide cell
  assign w_line = (w_row == 2'd0) ? 8'b0001_1000 :
                  (w_row == 2'd1) ? 8'b0011_1100 :
                  (w_row == 2'd2) ? 8'b0111_1110 : 8'b1111_1111;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = update ? CHECK : IDLE;
      CHECK:   w_next = (r_drawn && r_xr == r_pos && r_col == r_dcol) ? DONE :
                        r_drawn ? ERASE : DRAW;
      ERASE:   w_next = w_last ? DRAW : ERASE;
      DRAW:    w_next = w_last ? DONE : DRAW;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pos   <= '0;
      r_xr    <= '0;
      r_drawn <= 1'b0;
      r_col   <= '0;
      r_dcol  <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_act ? r_cnt + 5'd1 : 5'd0;
      if (r_state == IDLE && update) begin
        r_xr  <= (x_in > XMAX) ? XMAX : x_in;
        r_col <= colour;
      end
      if (w_last) r_pos <= r_xr;
      if (w_last && r_state == DRAW) begin
        r_drawn <= 1'b1;
        r_dcol  <= r_col;
      end
    end
  end
  assign vga_x      = (r_state == ERASE) ? r_pos + {5'd0, w_cidx} :
                      (r_state == DRAW)  ? r_xr + {5'd0, w_cidx} : 8'd0;
  assign vga_y      = w_act ? 7'(SHIP_Y) + {5'd0, w_row} : 7'd0;
  assign vga_colour = (r_state == ERASE) ? BG_COLOUR : (r_state == DRAW) ? r_col : 3'd0;
  assign vga_plot   = w_act && w_line[w_cidx];
  assign busy       = r_state != IDLE;
  assign done       = r_state == DONE;
endmodule
